// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the requester count, index width and the arbiter state encoding.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: returns the first set request bit at or after ptr.
// Purely combinational; the arbiter registers the result.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the loop, otherwise a request
    // pattern that assigns nothing would infer a latch.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Scan from farthest to nearest so the closest hit to ptr wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with done/req-drop release and a MAX_HOLD
// forced release; every output is driven straight from a flop.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic               valid_nx;
    logic               timeout_nx;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               expired;
    logic               holder_req;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        hold_nx    = hold_cnt;
        gnt_nx     = gnt;
        idx_nx     = gnt_idx;
        valid_nx   = gnt_valid;
        timeout_nx = 1'b0;
        expired    = (hold_cnt == HOLD_LAST);
        holder_req = req[gnt_idx];

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = BUSY;
                    gnt_nx   = idx_to_onehot(pick_idx);
                    idx_nx   = pick_idx;
                    valid_nx = 1'b1;
                    hold_nx  = '0;
                end else begin
                    gnt_nx   = '0;
                    idx_nx   = '0;
                    valid_nx = 1'b0;
                end
            end
            BUSY: begin
                if (done || !holder_req || expired) begin
                    state_nx   = IDLE;
                    gnt_nx     = '0;
                    idx_nx     = '0;
                    valid_nx   = 1'b0;
                    ptr_nx     = gnt_idx + IDX_W'(1);
                    // Only a pure expiry is a timeout; any normal release cause wins.
                    timeout_nx = !done && holder_req;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                idx_nx   = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: a cycle model feeds a scoreboard queue,
// and scenario tasks add directed checks on top.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit m_busy = 0;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_idx  = 0;
    bit m_to   = 0;

    rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_hold = 0; m_idx = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit found;
        m_to = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    found  = 1;
                    m_idx  = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_busy = 1;
                m_hold = 0;
            end
        end else begin
            if (done || !req[m_idx] || m_hold >= HOLD - 1) begin
                m_to   = !done && req[m_idx];
                m_ptr  = (m_idx + 1) % 8;
                m_busy = 0;
            end else if (m_hold < HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt   = m_busy ? 8'(1 << m_idx) : 8'h00;
        e.idx   = m_busy ? 3'(m_idx) : 3'd0;
        e.valid = m_busy;
        e.to    = m_to;
        return e;
    endfunction

    // One clock: predict, push, clock, then pop and compare against the DUT.
    task automatic tick();
        exp_t e;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: gnt=%h idx=%0d valid=%b to=%b expected gnt=%h idx=%0d valid=%b to=%b",
                     $time, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.to);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%h idx=%0d valid=%b to=%b expected all zero",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: valid=%b expected 0", gnt_valid);
        end
    endtask

    task automatic test_basic();
        req = 8'h81;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL first_grant: gnt=%h idx=%0d expected gnt=01 idx=0", gnt, gnt_idx);
        end
        done = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: gnt=%h valid=%b expected 00/0", gnt, gnt_valid);
        end
        done = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            errors++;
            $display("FAIL second_grant: gnt=%h idx=%0d expected gnt=80 idx=7", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            done = 1'b0;
            tick();
            checks++;
            if (gnt_idx !== 3'(k % 8) || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_%0d: idx=%0d valid=%b expected idx=%0d valid=1",
                         k, gnt_idx, gnt_valid, k % 8);
            end
            done = 1'b1;
            tick();
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotation_gap_%0d: valid=%b expected 0", k, gnt_valid);
            end
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        req = 8'h04;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            checks++;
            if (gnt_idx !== 3'd2 || gnt !== 8'h04 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: gnt=%h idx=%0d to=%b expected gnt=04 idx=2 to=0",
                         k, gnt, gnt_idx, timeout);
            end
        end
        req = 8'h0C;
        tick();
        checks++;
        if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: to=%b valid=%b expected to=1 valid=0", timeout, gnt_valid);
        end
        tick();
        checks++;
        if (gnt_idx !== 3'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout: idx=%0d to=%b expected idx=3 to=0", gnt_idx, timeout);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL revoked_regrant: idx=%0d valid=%b expected idx=2 valid=1", gnt_idx, gnt_valid);
        end
        done = 1'b1; req = 8'h00;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_done_expiry();
        req = 8'h02;
        for (int k = 0; k < HOLD; k++) tick();
        checks++;
        if (gnt_idx !== 3'd1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL last_hold_cycle: idx=%0d valid=%b expected idx=1 valid=1", gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_at_expiry: valid=%b to=%b expected valid=0 to=0", gnt_valid, timeout);
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_async_reset();
        req = 8'h20;
        tick();
        checks++;
        if (gnt !== 8'h20) begin
            errors++;
            $display("FAIL pre_reset_grant: gnt=%h expected 20", gnt);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%h valid=%b idx=%0d to=%b expected all zero",
                     gnt, gnt_valid, gnt_idx, timeout);
        end
        tick();
        rst = 1'b0; req = 8'h21;
        tick();
        checks++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_ptr: idx=%0d gnt=%h expected idx=0 gnt=01", gnt_idx, gnt);
        end
        done = 1'b1; req = 8'h00;
        tick();
        done = 1'b0;
    endtask

    task automatic test_req_drop();
        req = 8'h08;
        tick();
        req = 8'h28;
        tick();
        checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL busy_stable: gnt=%h idx=%0d expected gnt=08 idx=3", gnt, gnt_idx);
        end
        req = 8'h20;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: valid=%b to=%b expected 0/0", gnt_valid, timeout);
        end
        tick();
        checks++;
        if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
            errors++;
            $display("FAIL drop_next: idx=%0d gnt=%h expected idx=5 gnt=20", gnt_idx, gnt);
        end
        done = 1'b1; req = 8'h00;
        tick();
        done = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            done = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (!$onehot0(gnt) || gnt_valid !== (gnt != 8'h00)) begin
                errors++;
                $display("FAIL onehot_invariant: gnt=%h valid=%b", gnt, gnt_valid);
            end
        end
        req = 8'h00; done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_done_expiry();
        test_async_reset();
        test_req_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
